// File: rtl/snn_cmd_pkg.sv
// Shared constants, command codes, table entry layout and sequencer states
// for the spiking network command sequencer.
package snn_cmd_pkg;

    localparam int ADDR_WIDTH  = 3;
    localparam int CMD_WIDTH   = 3;
    localparam int FLOAT_WIDTH = 8;
    localparam int TBL_DEPTH   = 16;
    localparam int TBL_AW      = 4;
    localparam int MAX_TIME    = 35;
    localparam int EVAL_CYCLES = MAX_TIME + 2;
    localparam int RUN_CW      = $clog2(EVAL_CYCLES + 1);
    localparam int ENTRY_W     = ADDR_WIDTH + CMD_WIDTH + FLOAT_WIDTH;

    localparam logic [CMD_WIDTH-1:0] CMD_RUN               = 3'd0;
    localparam logic [CMD_WIDTH-1:0] CMD_SET_DELIVERY_TIME = 3'd3;
    localparam logic [CMD_WIDTH-1:0] CMD_SET_BIAS          = 3'd4;
    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR             = 3'd5;
    localparam logic [CMD_WIDTH-1:0] CMD_IDLE              = 3'd7;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [CMD_WIDTH-1:0]   cmd;
        logic [FLOAT_WIDTH-1:0] arg;
    } tbl_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_CLEAR,
        S_RUN,
        S_RESP
    } state_t;

endpackage

// File: rtl/snn_cmd_table.sv
// Configuration command table: one synchronous write port, one
// asynchronous read port. Contents survive reset on purpose.
module snn_cmd_table
    import snn_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [TBL_AW-1:0] waddr,
    input  tbl_entry_t        wdata,
    input  logic [TBL_AW-1:0] raddr,
    output tbl_entry_t        rdata
);

    tbl_entry_t mem [TBL_DEPTH];

    // Store an entry on a write strobe.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/snn_cmd_sequencer.sv
// Host-side command bus initiator: streams the configuration table onto
// the bus and runs single inferences (CLEAR, RUN for a fixed number of
// cycles, sample result, valid/ready return).
//
// state   | meaning
// S_IDLE  | waiting for cfg_start or an inference request
// S_CFG   | driving table entry idx on the bus, one per cycle
// S_CLEAR | one CLEAR command with the request argument on net_in
// S_RUN   | RUN commands, counting cycles until the sample point
// S_RESP  | holding the result until the host takes it
module snn_cmd_sequencer
    import snn_cmd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tbl_we,
    input  logic [TBL_AW-1:0]      tbl_waddr,
    input  logic [ENTRY_W-1:0]     tbl_wdata,
    input  logic [TBL_AW:0]        cfg_len,
    input  logic                   cfg_start,
    output logic                   cfg_done,
    input  logic                   eval_valid,
    output logic                   eval_ready,
    input  logic [1:0]             eval_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_out,
    output logic                   busy,
    output logic [ADDR_WIDTH-1:0]  net_addr,
    output logic [CMD_WIDTH-1:0]   net_cmd,
    output logic [FLOAT_WIDTH-1:0] net_arg,
    output logic [1:0]             net_in,
    input  logic                   net_out
);

    localparam logic [RUN_CW-1:0] EVAL_CNT = RUN_CW'(EVAL_CYCLES);

    state_t                 state, state_nxt;
    logic [TBL_AW-1:0]      idx, idx_nxt;
    logic [TBL_AW:0]        len_q, len_nxt;
    logic [1:0]             arg_q, arg_nxt;
    logic [RUN_CW-1:0]      run_cnt, run_cnt_nxt;
    logic [ADDR_WIDTH-1:0]  net_addr_nxt;
    logic [CMD_WIDTH-1:0]   net_cmd_nxt;
    logic [FLOAT_WIDTH-1:0] net_arg_nxt;
    logic [1:0]             net_in_nxt;
    logic                   cfg_done_nxt, res_valid_nxt, res_out_nxt;
    logic [TBL_AW-1:0]      rd_idx;
    tbl_entry_t             rd_entry;

    // The bus is registered, so the table is read one entry ahead of idx.
    assign rd_idx     = (state == S_CFG) ? idx + 1'b1 : '0;
    assign busy       = (state != S_IDLE);
    assign eval_ready = (state == S_IDLE) && !cfg_start;

    snn_cmd_table u_table (
        .clk   (clk),
        .we    (tbl_we && (state == S_IDLE)),
        .waddr (tbl_waddr),
        .wdata (tbl_entry_t'(tbl_wdata)),
        .raddr (rd_idx),
        .rdata (rd_entry)
    );

    // State and registered bus/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            len_q     <= '0;
            arg_q     <= '0;
            run_cnt   <= '0;
            net_addr  <= '0;
            net_cmd   <= CMD_IDLE;
            net_arg   <= '0;
            net_in    <= '0;
            cfg_done  <= 1'b0;
            res_valid <= 1'b0;
            res_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            len_q     <= len_nxt;
            arg_q     <= arg_nxt;
            run_cnt   <= run_cnt_nxt;
            net_addr  <= net_addr_nxt;
            net_cmd   <= net_cmd_nxt;
            net_arg   <= net_arg_nxt;
            net_in    <= net_in_nxt;
            cfg_done  <= cfg_done_nxt;
            res_valid <= res_valid_nxt;
            res_out   <= res_out_nxt;
        end
    end

    // Next-state logic; the bus falls back to IDLE unless a state drives it.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        len_nxt       = len_q;
        arg_nxt       = arg_q;
        run_cnt_nxt   = run_cnt;
        net_addr_nxt  = '0;
        net_cmd_nxt   = CMD_IDLE;
        net_arg_nxt   = '0;
        net_in_nxt    = '0;
        cfg_done_nxt  = 1'b0;
        res_valid_nxt = res_valid;
        res_out_nxt   = res_out;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_len == '0) begin
                        cfg_done_nxt = 1'b1;
                    end else begin
                        len_nxt      = cfg_len;
                        idx_nxt      = '0;
                        state_nxt    = S_CFG;
                        net_addr_nxt = rd_entry.addr;
                        net_cmd_nxt  = rd_entry.cmd;
                        net_arg_nxt  = rd_entry.arg;
                    end
                end else if (eval_valid) begin
                    arg_nxt     = eval_in;
                    state_nxt   = S_CLEAR;
                    net_cmd_nxt = CMD_CLEAR;
                    net_in_nxt  = eval_in;
                end
            end
            S_CFG: begin
                if ({1'b0, idx} == len_q - 1'b1) begin
                    state_nxt    = S_IDLE;
                    cfg_done_nxt = 1'b1;
                end else begin
                    idx_nxt      = idx + 1'b1;
                    net_addr_nxt = rd_entry.addr;
                    net_cmd_nxt  = rd_entry.cmd;
                    net_arg_nxt  = rd_entry.arg;
                end
            end
            S_CLEAR: begin
                state_nxt   = S_RUN;
                run_cnt_nxt = '0;
                net_cmd_nxt = CMD_RUN;
                net_in_nxt  = arg_q;
            end
            S_RUN: begin
                if (run_cnt == EVAL_CNT) begin
                    res_out_nxt   = net_out;
                    res_valid_nxt = 1'b1;
                    state_nxt     = S_RESP;
                end else begin
                    run_cnt_nxt = run_cnt + 1'b1;
                    net_cmd_nxt = CMD_RUN;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_snn_cmd_sequencer.sv
// Directed bench for snn_cmd_sequencer with a small network model that
// decides its output a set number of RUN cycles after CLEAR.
module tb_snn_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbl_we;
    logic [3:0]  tbl_waddr;
    logic [13:0] tbl_wdata;
    logic [4:0]  cfg_len;
    logic        cfg_start;
    logic        cfg_done;
    logic        eval_valid;
    logic        eval_ready;
    logic [1:0]  eval_in;
    logic        res_valid;
    logic        res_ready;
    logic        res_out;
    logic        busy;
    logic [2:0]  net_addr;
    logic [2:0]  net_cmd;
    logic [7:0]  net_arg;
    logic [1:0]  net_in;
    logic        net_out;

    int n_assert = 0;
    int n_fail   = 0;

    int   decide_at  = 0;
    logic decide_val = 1'b0;
    int   rc         = 0;

    always #5 clk = ~clk;

    snn_cmd_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_we     (tbl_we),
        .tbl_waddr  (tbl_waddr),
        .tbl_wdata  (tbl_wdata),
        .cfg_len    (cfg_len),
        .cfg_start  (cfg_start),
        .cfg_done   (cfg_done),
        .eval_valid (eval_valid),
        .eval_ready (eval_ready),
        .eval_in    (eval_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_out    (res_out),
        .busy       (busy),
        .net_addr   (net_addr),
        .net_cmd    (net_cmd),
        .net_arg    (net_arg),
        .net_in     (net_in),
        .net_out    (net_out)
    );

    // Network model: output cleared by CLEAR, set to decide_val once
    // decide_at RUN commands have been seen, then held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rc      <= 0;
            net_out <= 1'b0;
        end else if (net_cmd == 3'd5) begin
            rc      <= 0;
            net_out <= 1'b0;
        end else if (net_cmd == 3'd0) begin
            rc <= rc + 1;
            if (rc == decide_at) net_out <= decide_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string tag, input logic [13:0] exp);
        chk(tag, {18'd0, net_addr, net_cmd, net_arg}, {18'd0, exp});
    endtask

    // Present a request, check CLEAR and the first two RUN cycles.
    task automatic start_eval(input logic [1:0] a);
        eval_in = a; eval_valid = 1'b1;
        #1 chk("eval_ready_idle", eval_ready, 1);
        @(negedge clk);
        eval_valid = 1'b0;
        bus("clear_bus", {3'd0, 3'd5, 8'd0});
        chk("clear_net_in", net_in, a);
        chk("clear_busy", busy, 1);
        @(negedge clk);
        chk("run0_cmd", net_cmd, 0);
        chk("run0_net_in", net_in, a);
        @(negedge clk);
        chk("run1_cmd", net_cmd, 0);
        chk("run1_net_in", net_in, 0);
    endtask

    // Count edges since acceptance until res_valid; assumes 2 already seen.
    task automatic wait_res(output int e, output logic run_ok);
        e = 2; run_ok = 1'b1;
        while (!res_valid && e < 100) begin
            if (net_cmd != 3'd0 || net_in != 2'd0 || eval_ready) run_ok = 1'b0;
            @(negedge clk);
            e++;
        end
    endtask

    initial begin
        int   e;
        logic ok;
        rst = 1'b1; tbl_we = 0; tbl_waddr = 0; tbl_wdata = 0; cfg_len = 0;
        cfg_start = 0; eval_valid = 0; eval_in = 0; res_ready = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_cmd", net_cmd, 7);
        chk("rst_addr_arg", {net_addr, net_arg}, 0);
        chk("rst_net_in", net_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_eval_ready", eval_ready, 1);
        rst = 1'b0;

        // Table load and three-entry stream.
        tbl_we = 1;
        tbl_waddr = 0; tbl_wdata = {3'd1, 3'd3, 8'h12}; @(negedge clk);
        tbl_waddr = 1; tbl_wdata = {3'd2, 3'd4, 8'h80}; @(negedge clk);
        tbl_waddr = 2; tbl_wdata = {3'd7, 3'd4, 8'h05}; @(negedge clk);
        tbl_we = 0;
        cfg_len = 3; cfg_start = 1;
        #1 chk("cfg_start_blocks_ready", eval_ready, 0);
        @(negedge clk); cfg_start = 0;
        bus("cfg_e0", {3'd1, 3'd3, 8'h12});
        chk("cfg_busy0", busy, 1);
        chk("cfg_done_early", cfg_done, 0);
        @(negedge clk);
        bus("cfg_e1", {3'd2, 3'd4, 8'h80});
        chk("cfg_busy1", busy, 1);
        @(negedge clk);
        bus("cfg_e2", {3'd7, 3'd4, 8'h05});
        chk("cfg_busy2", busy, 1);
        @(negedge clk);
        chk("cfg_end_cmd", net_cmd, 7);
        chk("cfg_done", cfg_done, 1);
        chk("cfg_end_busy", busy, 0);
        @(negedge clk);
        chk("cfg_done_pulse", cfg_done, 0);

        // Zero-length stream.
        cfg_len = 0; cfg_start = 1;
        @(negedge clk); cfg_start = 0;
        chk("len0_done", cfg_done, 1);
        chk("len0_cmd", net_cmd, 7);
        chk("len0_busy", busy, 0);
        @(negedge clk);
        chk("len0_done_pulse", cfg_done, 0);
        chk("len0_cmd2", net_cmd, 7);

        // Inference 1: decides 1 early, res_ready already high.
        decide_at = 12; decide_val = 1; res_ready = 1;
        start_eval(2'b01);
        wait_res(e, ok);
        chk("ev1_latency", e, 39);
        chk("ev1_run_phase", ok, 1);
        chk("ev1_res_out", res_out, 1);
        chk("ev1_resp_cmd", net_cmd, 7);
        @(negedge clk);
        chk("ev1_valid_drop", res_valid, 0);
        chk("ev1_idle_ready", eval_ready, 1);
        chk("ev1_idle_busy", busy, 0);

        // Inference 2: undecided until fallback 0, host stalls 5 cycles.
        decide_at = 35; decide_val = 0; res_ready = 0;
        start_eval(2'b11);
        wait_res(e, ok);
        chk("ev2_latency", e, 39);
        chk("ev2_run_phase", ok, 1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_out !== 1'b0 || eval_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("ev2_hold_stable", ok, 1);
        chk("ev2_res_out", res_out, 0);
        chk("ev2_still_valid", res_valid, 1);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("ev2_valid_drop", res_valid, 0);
        chk("ev2_idle_ready", eval_ready, 1);

        // Reset at run_cnt=10; a table write during the run must be dropped.
        decide_at = 3; decide_val = 1;
        start_eval(2'b10);
        tbl_we = 1; tbl_waddr = 0; tbl_wdata = {3'd5, 3'd5, 8'hAA};
        for (int i = 0; i < 9; i++) @(negedge clk);
        tbl_we = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_run_cmd", net_cmd, 7);
        chk("rst_run_net_in", net_in, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_valid", res_valid, 0);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (res_valid !== 1'b0 || cfg_done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("rst_run_no_result", ok, 1);
        cfg_len = 1; cfg_start = 1;
        @(negedge clk); cfg_start = 0;
        bus("tbl_kept_e0", {3'd1, 3'd3, 8'h12});
        @(negedge clk);
        chk("len1_done", cfg_done, 1);

        // cfg_start and eval_valid together: config first, then request.
        decide_at = 5; decide_val = 1; res_ready = 1;
        cfg_len = 2; cfg_start = 1; eval_valid = 1; eval_in = 2'b01;
        #1 chk("both_ready_low", eval_ready, 0);
        @(negedge clk); cfg_start = 0;
        bus("both_e0", {3'd1, 3'd3, 8'h12});
        chk("both_cfg_ready", eval_ready, 0);
        @(negedge clk);
        bus("both_e1", {3'd2, 3'd4, 8'h80});
        @(negedge clk);
        chk("both_done", cfg_done, 1);
        chk("both_accept_ready", eval_ready, 1);
        @(negedge clk); eval_valid = 0;
        chk("both_clear_cmd", net_cmd, 5);
        chk("both_clear_in", net_in, 1);
        @(negedge clk); @(negedge clk);
        wait_res(e, ok);
        chk("both_latency", e, 39);
        chk("both_res_out", res_out, 1);
        @(negedge clk);
        chk("both_valid_drop", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
